// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, func3 encodings and store-lane helpers for the LSU memory port.
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return we ? (f3 >= 3'b011) : (f3 == 3'b011 || f3 >= 3'b110);
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
  function automatic logic [3:0] store_be(input logic we, input logic [2:0] f3, input logic [1:0] off);
    return !we ? 4'b1111 : f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    return f3[1:0] == 2'b00 ? {4{wd[7:0]}} : f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
  endfunction
endpackage

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: valid/ready request plus single-cycle response data-memory bus.
interface lsu_mem_port_if;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [3:0]  mem_req_be;
  modport master(output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
                 input mem_req_ready, mem_resp_valid, mem_resp_rdata);
  modport slave(input mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
                output mem_req_ready, mem_resp_valid, mem_resp_rdata);
endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: selects the addressed byte/halfword of a read word and sign/zero extends it.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = func3_i == F3_B  ? {{24{byte_sel[7]}}, byte_sel} :
               func3_i == F3_BU ? {24'b0, byte_sel} :
               func3_i == F3_H  ? {{16{half_sel[15]}}, half_sel} :
               func3_i == F3_HU ? {16'b0, half_sel} : rdata_i;
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: runs MEM-stage loads/stores on the data bus and stalls the pipeline meanwhile.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses without a bus request.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           data_mem_rd_en_i,
  input  logic           data_mem_wr_en_i,
  input  logic [2:0]     func3_i,
  input  logic [31:0]    addr_i,
  input  logic [31:0]    wdata_i,
  output logic [31:0]    load_data_o,
  output logic           stall_o,
  output logic           done_o,
  output logic           lsu_err_o,
  lsu_mem_port_if.master mem
);
  localparam logic [7:0] TO = TIMEOUT_CYC[7:0];
  lsu_state_t  state_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;
  logic [31:0] ext;
  logic        req, bad;
  always_comb begin
    req = data_mem_rd_en_i | data_mem_wr_en_i;
`ifdef LSU_MISALIGN_TRAP_EN
    bad = f3_illegal(data_mem_wr_en_i, func3_i) | misaligned(func3_i, addr_i[1:0]);
`else
    bad = f3_illegal(data_mem_wr_en_i, func3_i);
`endif
  end
  assign stall_o = (state_q == IDLE && req) || state_q == REQ || state_q == WAIT;
  lsu_load_ext u_ext (.func3_i(f3_q), .off_i(off_q), .rdata_i(mem.mem_resp_rdata), .result_o(ext));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q           <= IDLE;
      f3_q              <= '0;
      off_q             <= '0;
      cnt_q             <= '0;
      done_o            <= 1'b0;
      lsu_err_o         <= 1'b0;
      load_data_o       <= '0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_we    <= 1'b0;
      mem.mem_req_addr  <= '0;
      mem.mem_req_wdata <= '0;
      mem.mem_req_be    <= '0;
    end else begin
      done_o    <= 1'b0;
      lsu_err_o <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          f3_q  <= func3_i;
          off_q <= addr_i[1:0];
          cnt_q <= '0;
          if (bad) begin
            state_q     <= DONE;
            done_o      <= 1'b1;
            lsu_err_o   <= 1'b1;
            load_data_o <= '0;
          end else begin
            state_q           <= REQ;
            mem.mem_req_valid <= 1'b1;
            mem.mem_req_we    <= data_mem_wr_en_i;
            mem.mem_req_addr  <= {addr_i[31:2], 2'b00};
            mem.mem_req_wdata <= store_wdata(func3_i, wdata_i);
            mem.mem_req_be    <= store_be(data_mem_wr_en_i, func3_i, addr_i[1:0]);
          end
        end
        REQ: if (mem.mem_req_ready) begin
          mem.mem_req_valid <= 1'b0;
          cnt_q             <= '0;
          state_q           <= mem.mem_req_we ? DONE : WAIT;
          done_o            <= mem.mem_req_we;
          if (mem.mem_req_we) load_data_o <= '0;
        end else if (cnt_q + 8'd1 == TO) begin
          mem.mem_req_valid <= 1'b0;
          state_q           <= DONE;
          done_o            <= 1'b1;
          lsu_err_o         <= 1'b1;
          load_data_o       <= '0;
        end else cnt_q <= cnt_q + 8'd1;
        WAIT: if (mem.mem_resp_valid) begin
          state_q     <= DONE;
          done_o      <= 1'b1;
          load_data_o <= ext;
        end else if (cnt_q + 8'd1 == TO) begin
          state_q     <= DONE;
          done_o      <= 1'b1;
          lsu_err_o   <= 1'b1;
          load_data_o <= '0;
        end else cnt_q <= cnt_q + 8'd1;
        DONE: state_q <= IDLE;
      endcase
    end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Responder side of the controller's memory-control outputs: consumes data_mem_rd_en / data_mem_wr_en with func3, address and store data from the MEM stage.
- Runs a valid/ready request plus response transaction on the data-memory bus.
- Stalls the pipeline while a transaction is in flight.
- Returns byte-lane-aligned, sign- or zero-extended load data to writeback (wb_sel=01 path).

Parameters:
- TIMEOUT_CYC, 255: maximum cycles spent in REQ or WAIT before the transaction is aborted with an error; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- data_mem_rd_en  in  1  load request from controller
- data_mem_wr_en  in  1  store request from controller
- func3  in  3  instr[14:12], selects access size and sign
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- load_data  out  32  extended load result, valid while done=1
- stall  out  1  hold the pipeline (PC, IF/ID, ID/EX, EX/MEM)
- done  out  1  one-cycle pulse: access complete
- lsu_err  out  1  one-cycle pulse with done: illegal func3, timeout or misalign
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts the request
- mem_req_we  out  1  1 = write
- mem_req_addr  out  32  word address, {addr[31:2],2'b00}
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_be  out  4  byte enables
- mem_resp_valid  in  1  read response valid, single cycle
- mem_resp_rdata  in  32  read word

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops mem_req_valid immediately. A mem_resp_valid that arrives in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If rd_en or wr_en is set, capture func3, addr, wdata and type. wr_en wins if both are set.
  - Go to REQ, or to DONE with lsu_err if func3 is illegal.
  - Illegal loads: 011, 110, 111. Illegal stores: any func3 at or above 011.
- stall = (state==IDLE && (rd_en||wr_en)) || state==REQ || state==WAIT. stall is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- REQ:
  - mem_req_valid=1. Address, data, be and we are held stable until the handshake.
  - On valid&&ready: a store goes to DONE (posted write); a load goes to WAIT.
- WAIT: on mem_resp_valid, register the extended data and go to DONE.
- Timeout: the counter clears on entry to REQ and to WAIT. When it reaches TIMEOUT_CYC: go to DONE, lsu_err=1, load_data=0, mem_req_valid drops.
- DONE: done=1 and load_data valid for exactly one cycle, then IDLE. done=0 in every other state.
- Byte enables:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
  - Loads: be=4'b1111, we=0.
- Load extension:
  - LB/LBU select the byte at addr[1:0]; LH/LHU select the halfword at addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Minimum latency with ready=1 and response on the next cycle:
  - Load: capture (IDLE), REQ, WAIT, DONE = 4 cycles, stall high for 3.
  - Store: 3 cycles, stall high for 2.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - Misalignment is checked in IDLE: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - A misaligned access goes to DONE directly with lsu_err=1, no bus request, and load_data=0.
- LSU_MISALIGN_TRAP_EN undefined: no misalignment check; the halfword ignores addr[0] and the word ignores addr[1:0].

Decomposition:
- Package lsu_pkg:
  - lsu_state_t enum (IDLE, REQ, WAIT, DONE).
  - func3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - OP_LOAD=7'b0000011, OP_STORE=7'b0100011 for bench use.
- Sub-module lsu_load_ext: combinational lane select plus sign/zero extension (func3, addr[1:0], rdata -> 32-bit result).

Test Plan:
- LW addr=0x100, ready=1, resp one cycle later with 0xDEADBEEF -> stall high 3 cycles, done with load_data=0xDEADBEEF, mem_req_addr=0x100, be=1111.
- LB addr=0x103, rdata=0x80000000 -> load_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr=0x102, rdata=0xABCD0000 -> 0x0000ABCD.
- SB addr=0x201, wdata=0x12345678, ready held low 3 cycles -> valid, be=0010, wdata=0x78787878 stable throughout. done 1 cycle after the handshake, no WAIT state.
- LW with no response, TIMEOUT_CYC=4 -> after 4 WAIT cycles: done=1, lsu_err=1, load_data=0, FSM back to IDLE.
- Load func3=3'b111 -> no mem_req_valid, done and lsu_err on the next cycle.
- rst asserted during WAIT, then a late mem_resp_valid -> outputs 0 immediately, response ignored. With LSU_MISALIGN_TRAP_EN: SW at addr=0x102 -> lsu_err=1 and no bus activity.
